// File: rtl/pdm_pkg.sv
// Shared constants, CIC width helper and comb-pipeline state type for the PDM microphone receiver.
package pdm_pkg;

  localparam int unsigned CLK_DIV_DEF = 40;
  localparam int unsigned DECIM_DEF   = 64;
  localparam int unsigned OUT_W       = 16;

  // Worst-case growth of a 2nd-order CIC: 2*log2(R) bits plus sign and the +/-1 input.
  function automatic int unsigned cic_width(input int unsigned decim);
    return 2 * $clog2(decim) + 2;
  endfunction

  typedef enum logic [1:0] {
    CombIdle,
    CombStage1,
    CombStage2
  } comb_state_e;

endpackage

// File: rtl/pdm_cic2_decim.sv
// Second-order CIC decimator: two modular integrators, a two-cycle comb pipeline and a
// warm-up gate that hides the first two (not yet settled) decimated results.
module pdm_cic2_decim
  import pdm_pkg::*;
#(
  parameter int unsigned DECIM = DECIM_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             bit_strobe,
  input  logic             bit_val,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid
);

  localparam int unsigned B  = cic_width(DECIM);
  localparam int unsigned CW = $clog2(DECIM);

  logic [B-1:0]     r_i1, r_i2, r_i2_prev, r_c1, r_c1_prev;
  logic [CW-1:0]    r_bit_cnt;
  logic [1:0]       r_warm;
  logic [OUT_W-1:0] r_sample;
  logic             r_valid;
  comb_state_e      r_state, w_state_next;

  logic [B-1:0]     w_x, w_i1_next, w_i2_next, w_c2;
  logic [OUT_W-1:0] w_sample_next;
  logic             w_decim;

  assign w_x       = bit_val ? B'(1) : {B{1'b1}};
  assign w_i1_next = r_i1 + w_x;
  assign w_i2_next = r_i2 + w_i1_next;
  assign w_c2      = r_c1 - r_c1_prev;
  assign w_decim   = bit_strobe && (r_bit_cnt == CW'(DECIM - 1));
  // The bits that sign extension would add are shifted out, so zero-extend then shift.
  assign w_sample_next = OUT_W'(w_c2) << (OUT_W - B);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= CombIdle;
    end else if (clk_enable) begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      CombIdle:   if (w_decim) w_state_next = CombStage1;
      CombStage1: w_state_next = CombStage2;
      CombStage2: w_state_next = CombIdle;
      default:    w_state_next = CombIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_i1      <= '0;
      r_i2      <= '0;
      r_i2_prev <= '0;
      r_c1      <= '0;
      r_c1_prev <= '0;
      r_bit_cnt <= '0;
      r_warm    <= '0;
      r_sample  <= '0;
      r_valid   <= 1'b0;
    end else if (clk_enable) begin
      r_valid <= 1'b0;
      if (bit_strobe) begin
        r_i1      <= w_i1_next;
        r_i2      <= w_i2_next;
        r_bit_cnt <= r_bit_cnt + CW'(1);
      end
      // I2 cannot change again for at least CLK_DIV cycles, so it is read directly here.
      if (r_state == CombStage1) begin
        r_c1      <= r_i2 - r_i2_prev;
        r_i2_prev <= r_i2;
      end
      if (r_state == CombStage2) begin
        r_c1_prev <= r_c1;
        if (r_warm == 2'd2) begin
          r_sample <= w_sample_next;
          r_valid  <= 1'b1;
        end else begin
          r_warm <= r_warm + 2'd1;
        end
      end
    end
  end

  assign sample       = r_sample;
  assign sample_valid = r_valid & clk_enable;

endmodule

// File: rtl/pdm_mic_rx.sv
// PDM microphone receiver top: bit-clock divider, 2-flop input synchronizer and the capture
// strobe feeding the CIC decimator.
module pdm_mic_rx
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF,
  parameter int unsigned DECIM   = DECIM_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_enable,
  input  logic             mic_data,
  output logic             mic_clk,
  output logic             mic_lrsel,
  output logic [OUT_W-1:0] sample,
  output logic             sample_valid
);

  localparam int unsigned DW = $clog2(CLK_DIV);

  logic [DW-1:0] r_div_cnt;
  logic          r_mic_clk;
  logic [1:0]    r_sync;
  logic          w_div_last, w_div_half;

  assign w_div_last = (r_div_cnt == DW'(CLK_DIV - 1));
  assign w_div_half = (r_div_cnt == DW'(CLK_DIV / 2 - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_mic_clk <= 1'b0;
      r_sync    <= '0;
    end else if (clk_enable) begin
      r_div_cnt <= w_div_last ? '0 : r_div_cnt + DW'(1);
      if (w_div_last) begin
        r_mic_clk <= 1'b1;
      end else if (w_div_half) begin
        r_mic_clk <= 1'b0;
      end
      r_sync <= {r_sync[0], mic_data};
    end
  end

  // Capture happens one cycle before mic_clk rises, closing the current bit period.
  pdm_cic2_decim #(
    .DECIM(DECIM)
  ) u_cic (
    .clk          (clk),
    .reset        (reset),
    .clk_enable   (clk_enable),
    .bit_strobe   (w_div_last),
    .bit_val      (r_sync[1]),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  assign mic_clk   = r_mic_clk;
  assign mic_lrsel = 1'b0;

endmodule

// File: tb/tb_pdm_mic_rx.sv
// Directed bench for pdm_mic_rx: divider timing, warm-up, DC levels, enable freeze and reset.
module tb_pdm_mic_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        mic_data;
  logic        mic_clk;
  logic        mic_lrsel;
  logic [15:0] sample;
  logic        sample_valid;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit alt_mode = 1'b0;
  logic prev_mclk = 1'b0;

  pdm_mic_rx #(
    .CLK_DIV(40),
    .DECIM  (64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_enable   (clk_enable),
    .mic_data     (mic_data),
    .mic_clk      (mic_clk),
    .mic_lrsel    (mic_lrsel),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (alt_mode && mic_clk && !prev_mclk) mic_data = ~mic_data;
    prev_mclk = mic_clk;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sample_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_vec++;
      n_err++;
      $error("FAIL wait_valid: observed no pulse expected sample_valid within %0d cycles", budget);
    end
  endtask

  initial begin
    int rise1, rise2, fall1, early, t_last, t, lvl, bad;
    logic pm;

    reset      = 1'b1;
    clk_enable = 1'b1;
    mic_data   = 1'b1;
    repeat (3) tick();
    check("rst_mic_clk", 32'(mic_clk), 32'h0);
    check("rst_sample", 32'(sample), 32'h0);
    check("rst_valid", 32'(sample_valid), 32'h0);
    check("lrsel", 32'(mic_lrsel), 32'h0);

    // Reset release, constant 1s: divider timing and warm-up.
    reset = 1'b0;
    cyc   = 0;
    rise1 = -1; rise2 = -1; fall1 = -1; early = 0; pm = mic_clk;
    while (cyc < 7681) begin
      tick();
      if (mic_clk && !pm) begin
        if (rise1 < 0) rise1 = cyc;
        else if (rise2 < 0) rise2 = cyc;
      end
      if (!mic_clk && pm && fall1 < 0) fall1 = cyc;
      if (sample_valid) early++;
      pm = mic_clk;
    end
    check("first_rise", 32'(rise1), 32'd40);
    check("first_fall", 32'(fall1), 32'd60);
    check("second_rise", 32'(rise2), 32'd80);
    check("no_early_valid", 32'(early), 32'd0);
    check("lrsel_run", 32'(mic_lrsel), 32'h0);
    tick();
    check("first_valid", 32'(sample_valid), 32'h1);
    check("ones_first", 32'(sample), 32'h4000);
    tick();
    check("valid_one_cycle", 32'(sample_valid), 32'h0);
    t_last = 7682;
    for (int k = 0; k < 3; k++) begin
      wait_valid(2600, t);
      check("ones_period", 32'(t - t_last), 32'd2560);
      check("ones_sample", 32'(sample), 32'h4000);
      t_last = t;
    end

    // Constant 0s: settles to -16384.
    mic_data = 1'b0;
    wait_valid(2600, t);
    wait_valid(2600, t);
    for (int k = 0; k < 2; k++) begin
      wait_valid(2600, t);
      check("zeros_sample", 32'(sample), 32'h0000_C000);
    end

    // Alternating bits per mic_clk period: near zero.
    alt_mode = 1'b1;
    wait_valid(2600, t);
    wait_valid(2600, t);
    for (int k = 0; k < 2; k++) begin
      wait_valid(2600, t);
      n_vec++;
      assert ($signed(sample) >= -16'sd4 && $signed(sample) <= 16'sd4) else begin
        n_err++;
        $error("FAIL alt_sample: observed %0d expected within -4..4", $signed(sample));
      end
    end
    alt_mode = 1'b0;

    // clk_enable low for 1000 cycles mid-window.
    mic_data = 1'b1;
    wait_valid(2600, t);
    wait_valid(2600, t);
    wait_valid(2600, t_last);
    repeat (1000) tick();
    lvl = int'(mic_clk);
    bad = 0;
    clk_enable = 1'b0;
    repeat (1000) begin
      tick();
      if (int'(mic_clk) != lvl || sample_valid) bad++;
    end
    clk_enable = 1'b1;
    check("freeze_hold", 32'(bad), 32'd0);
    wait_valid(3700, t);
    check("freeze_delay", 32'(t - t_last), 32'd3560);
    check("freeze_sample", 32'(sample), 32'h4000);
    t_last = t;

    // clk_enable low with a comb result pending.
    while (cyc < t_last + 2558) tick();
    clk_enable = 1'b0;
    repeat (10) tick();
    clk_enable = 1'b1;
    wait_valid(100, t);
    check("pending_delay", 32'(t - t_last), 32'd2570);
    check("pending_sample", 32'(sample), 32'h4000);
    tick();
    check("pending_no_dup", 32'(sample_valid), 32'h0);
    t_last = t;

    // Reset one cycle after a decimating capture: result dropped, warm-up restarts.
    while (cyc < t_last + 2559) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cyc   = 0;
    check("mid_rst_sample", 32'(sample), 32'h0);
    check("mid_rst_valid", 32'(sample_valid), 32'h0);
    early = 0;
    while (cyc < 7681) begin
      tick();
      if (sample_valid) early++;
    end
    check("rewarm_no_valid", 32'(early), 32'd0);
    check("rewarm_sample_zero", 32'(sample), 32'h0);
    tick();
    check("rewarm_valid", 32'(sample_valid), 32'h1);
    check("rewarm_sample", 32'(sample), 32'h4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pdm_mic_rx.md
# pdm_mic_rx

PDM microphone receiver, the input-side counterpart of the audio core's PDM output path. It generates the microphone bit clock, samples the 1-bit PDM stream, and decimates it with a 2nd-order CIC filter into signed 16-bit PCM samples. Each sample is presented with a one-cycle valid strobe for downstream processing or loopback to the audio output. It sits at the board top next to `audio_core` and runs on the same 100 MHz clock.

## Interface
- `CLK_DIV`, 40: clk cycles per mic_clk period; must be even and ≥ 4. 100 MHz / 40 = 2.5 MHz.
- `DECIM`, 64: PDM bits per output sample; must be a power of 2, 4..128.
- `clk`  in  1  system clock, 100 MHz. One clock domain only.
- `reset`  in  1  synchronous, active-high reset.
- `clk_enable`  in  1  when low, every register holds its value and `sample_valid` is forced to 0.
- `mic_data`  in  1  PDM data pin; asynchronous to `clk`.
- `mic_clk`  out  1  PDM bit clock to the microphone.
- `mic_lrsel`  out  1  constant 0, selecting the rising-edge channel.
- `sample`  out  16  signed PCM sample, two's complement.
- `sample_valid`  out  1  one-cycle pulse when `sample` updates.

## Operation
- Reset values: `mic_clk`=0, `sample`=0, `sample_valid`=0. All counters, integrators, comb delays and synchronizer flops are 0.
- Clock divider: `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - When `div_cnt`=CLK_DIV-1, the next `mic_clk` is 1 (rising edge).
  - When `div_cnt`=CLK_DIV/2-1, the next `mic_clk` is 0.
- Synchronizer: `mic_data` passes through 2 flops, `sync_d`.
- Capture: on the cycle where `div_cnt`=CLK_DIV-1, `sync_d` is taken as the bit for the period that is ending. Mapping: 1 → x=+1, 0 → x=-1.
- CIC filter, internal width B = 2·log2(DECIM)+2 (14 for DECIM=64). Require B ≤ 16.
  - On each capture: I1 += x, then I2 += I1.
  - Both integrators use modular two's-complement arithmetic; wrap-around is intentional and must not saturate.
- Decimation: `bit_cnt` counts 0..DECIM-1 and advances on each capture. On the capture where `bit_cnt`=DECIM-1, I2 is latched to start a comb update.
  - Stage 1 (next cycle): C1 = I2 − I2_prev; I2_prev ← I2.
  - Stage 2 (following cycle): C2 = C1 − C1_prev; C1_prev ← C1; `sample` ← sign-extend(C2) << (16−B); `sample_valid`=1.
- Output range for DECIM=64: ±4096·4 = ±16384 (0x4000 / 0xC000).
- Warm-up: the first 2 decimated results after reset are computed but not flagged. `sample` stays 0 and `sample_valid` stays 0 for them. A 2-bit warm-up counter saturates once warm-up is complete.
- `mic_lrsel` is tied to 0 and is not affected by reset.

## Timing
- `mic_clk`: period CLK_DIV, 50% duty. The first rising edge comes CLK_DIV cycles after reset deasserts.
- `mic_data` to captured bit: 2 cycles of synchronizer latency. The bit is captured 1 cycle before `mic_clk` rises, i.e. at the end of the previous bit period.
- `sample_valid` is asserted exactly 2 cycles after the decimating capture cycle.
- Steady-state `sample_valid` period is CLK_DIV·DECIM = 2560 cycles (39.0625 kHz).
- The first `sample_valid` comes on the 3rd decimation boundary: 3·2560+2 cycles after reset, with all enables high.
- `clk_enable` low mid-operation: all phase relationships freeze and resume unchanged. A pending comb stage completes after enable returns. No pulse is lost or duplicated.
- `reset` mid-operation: all state returns to reset values on the next edge, including the warm-up counter. Any pending comb result is discarded.

## Structure
- Package `pdm_pkg`:
  - localparam function computing B from DECIM.
  - Default constants CLK_DIV_DEF=40, DECIM_DEF=64, OUT_W=16.
- Sub-module `pdm_cic2_decim`:
  - Holds the integrators, `bit_cnt`, comb pipeline and warm-up logic.
  - Inputs: `bit_strobe`, `bit_val`.
  - Outputs: `sample`, `sample_valid`.
- The top level `pdm_mic_rx` contains the divider, synchronizer and capture strobe.

## Test plan
- Reset release with `mic_data` idle: `mic_clk` first rises at cycle 40 and then has period 40 with 20 high; `mic_lrsel`=0; no `sample_valid` before cycle 3·2560+2.
- `mic_data` constant 1: after warm-up every sample = 16384 (0x4000), with valid pulses exactly 2560 cycles apart.
- `mic_data` constant 0: steady sample = −16384 (0xC000). Alternating 1/0 per mic_clk period: steady sample = 0 ± 4.
- Long run of all 1s (> 2^14 bits): integrators wrap, yet output stays 0x4000, proving modular arithmetic.
- `clk_enable` low for 1000 cycles in the middle of a window: `mic_clk` holds level and the next `sample_valid` is delayed by exactly 1000 cycles. Assert `reset` 1 cycle after a decimating capture: no `sample_valid`, `sample`=0, and the warm-up restarts.
